// File: rtl/w_stage_grf_pkg.sv
// Shared instruction-field constants and writeback source encoding for the W stage.
package w_stage_grf_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;

  localparam logic [5:0] FN_SLL    = 6'h00;
  localparam logic [5:0] FN_SRL    = 6'h02;
  localparam logic [5:0] FN_SRA    = 6'h03;
  localparam logic [5:0] FN_SLLV   = 6'h04;
  localparam logic [5:0] FN_SRLV   = 6'h06;
  localparam logic [5:0] FN_SRAV   = 6'h07;
  localparam logic [5:0] FN_JALR   = 6'h09;
  localparam logic [5:0] FN_MFHI   = 6'h10;
  localparam logic [5:0] FN_MFLO   = 6'h12;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUBU   = 6'h23;
  localparam logic [5:0] FN_AND    = 6'h24;
  localparam logic [5:0] FN_OR     = 6'h25;
  localparam logic [5:0] FN_XOR    = 6'h26;
  localparam logic [5:0] FN_NOR    = 6'h27;
  localparam logic [5:0] FN_SLT    = 6'h2a;
  localparam logic [5:0] FN_SLTU   = 6'h2b;

  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam logic [4:0] REG_RA    = 5'd31;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_DM  = 2'd1,
    WD_PC8 = 2'd2,
    WD_MDU = 2'd3
  } wd_sel_e;

endpackage

// File: rtl/w_stage_grf_dest_decode.sv
// Pure decode of the W-stage instruction into destination register and data source.
// A destination of 0 means "no write"; the top qualifies it against reset and ZERO_REG.
module w_dest_decode
  import w_stage_grf_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic        b_jump_i,
  output logic [4:0]  a3_o,
  output logic [1:0]  sel_o
);

  logic [5:0] op, fn;
  logic [4:0] rt, rd;
  logic       unused_bits;

  assign op = instr_i[31:26];
  assign rt = instr_i[20:16];
  assign rd = instr_i[15:11];
  assign fn = instr_i[5:0];
  assign unused_bits = ^{instr_i[25:21], instr_i[10:6]};

  always_comb begin
    a3_o  = 5'd0;
    sel_o = WD_ALU;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU: a3_o = rd;
          FN_MFHI, FN_MFLO: begin
            a3_o  = rd;
            sel_o = WD_MDU;
          end
          FN_JALR: begin
            a3_o  = rd;
            sel_o = WD_PC8;
          end
          default: ;
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        a3_o = rt;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        a3_o  = rt;
        sel_o = WD_DM;
      end
      OP_JAL: begin
        a3_o  = REG_RA;
        sel_o = WD_PC8;
      end
      OP_REGIMM: begin
        // Conditional-link branches only link when actually taken.
        if ((rt == RT_BGEZAL || rt == RT_BLTZAL) && b_jump_i) begin
          a3_o  = REG_RA;
          sel_o = WD_PC8;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/w_stage_grf.sv
// Writeback stage: destination decode, 32x32 register file with write-through read ports.
// Optional GRF_TRACE_EN compiles in a per-write trace print.
module w_stage_grf
  import w_stage_grf_pkg::*;
#(
  parameter logic [31:0] LINK_OFFSET = 32'd8,
  parameter logic [4:0]  ZERO_REG    = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] W_PC,
  input  logic [31:0] W_Instr,
  input  logic [31:0] W_ALUAns,
  input  logic [31:0] W_DMRD,
  input  logic        W_b_jump,
  input  logic [31:0] W_MDUAns,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  output logic [31:0] D_RD1,
  output logic [31:0] D_RD2,
  output logic [4:0]  W_A3,
  output logic [31:0] W_WD,
  output logic        W_WE
);

  logic [31:0] grf_q [32];
  logic [4:0]  dec_a3;
  logic [1:0]  dec_sel;
  logic [31:0] wd_raw;

  w_dest_decode u_dec (
    .instr_i  (W_Instr),
    .b_jump_i (W_b_jump),
    .a3_o     (dec_a3),
    .sel_o    (dec_sel)
  );

  always_comb begin
    wd_raw = W_ALUAns;
    case (dec_sel)
      WD_DM:   wd_raw = W_DMRD;
      WD_PC8:  wd_raw = W_PC + LINK_OFFSET;
      WD_MDU:  wd_raw = W_MDUAns;
      default: wd_raw = W_ALUAns;
    endcase
  end

  // Squash A3/WD when not writing so the forwarding unit can never match.
  assign W_WE = reset & (dec_a3 != ZERO_REG);
  assign W_A3 = W_WE ? dec_a3 : 5'd0;
  assign W_WD = W_WE ? wd_raw : 32'd0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) grf_q[i] <= 32'd0;
    end else if (W_WE) begin
      grf_q[W_A3] <= W_WD;
    end
  end

  always_comb begin
    if (D_A1 == ZERO_REG)                D_RD1 = 32'd0;
    else if (W_WE && D_A1 == W_A3)       D_RD1 = W_WD;
    else                                 D_RD1 = grf_q[D_A1];
    if (D_A2 == ZERO_REG)                D_RD2 = 32'd0;
    else if (W_WE && D_A2 == W_A3)       D_RD2 = W_WD;
    else                                 D_RD2 = grf_q[D_A2];
  end

`ifdef GRF_TRACE_EN
  always @(posedge clk) begin
    if (reset && W_WE) $display("@%h: $%d <= %h", W_PC, W_A3, W_WD);
  end
`endif

endmodule

// File: tb/tb_w_stage_grf.sv
// Randomized bench for w_stage_grf against an instruction-level register-file model,
// plus directed writes with hand-computed expectations.
`timescale 1ns/1ps
module tb_w_stage_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] W_PC, W_Instr, W_ALUAns, W_DMRD, W_MDUAns;
  logic        W_b_jump;
  logic [4:0]  D_A1, D_A2;
  logic [31:0] D_RD1, D_RD2, W_WD;
  logic [4:0]  W_A3;
  logic        W_WE;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [31:0] model_rf [32];

  w_stage_grf dut (
    .clk(clk), .reset(reset), .W_PC(W_PC), .W_Instr(W_Instr), .W_ALUAns(W_ALUAns),
    .W_DMRD(W_DMRD), .W_b_jump(W_b_jump), .W_MDUAns(W_MDUAns), .D_A1(D_A1), .D_A2(D_A2),
    .D_RD1(D_RD1), .D_RD2(D_RD2), .W_A3(W_A3), .W_WD(W_WD), .W_WE(W_WE)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of the W instruction: {dest, data}; dest 0 means no write.
  function automatic logic [36:0] arch_wb(input logic [31:0] ins, input logic [31:0] pc,
      input logic [31:0] alu, input logic [31:0] dm, input logic bj, input logic [31:0] mdu);
    logic [5:0] op, fn;
    logic [4:0] rt, rd;
    op = ins[31:26]; fn = ins[5:0]; rt = ins[20:16]; rd = ins[15:11];
    arch_wb = 37'd0;
    if (op == 6'd0) begin
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23,
                     6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b}) arch_wb = {rd, alu};
      else if (fn == 6'h10 || fn == 6'h12) arch_wb = {rd, mdu};
      else if (fn == 6'h09) arch_wb = {rd, pc + 32'd8};
    end else if (op inside {6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f}) arch_wb = {rt, alu};
    else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) arch_wb = {rt, dm};
    else if (op == 6'h03) arch_wb = {5'd31, pc + 32'd8};
    else if (op == 6'h01 && bj && (rt == 5'b10000 || rt == 5'b10001)) arch_wb = {5'd31, pc + 32'd8};
  endfunction

  // Compare process: every cycle, outputs against the model, then retire the W instruction.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [36:0] wb;
      logic [4:0]  a3;
      logic [31:0] wd, r1, r2;
      logic        we;
      wb = arch_wb(W_Instr, W_PC, W_ALUAns, W_DMRD, W_b_jump, W_MDUAns);
      we = reset && (wb[36:32] != 5'd0);
      a3 = we ? wb[36:32] : 5'd0;
      wd = we ? wb[31:0] : 32'd0;
      r1 = (D_A1 == 0) ? 32'd0 : (we && D_A1 == a3) ? wd : model_rf[D_A1];
      r2 = (D_A2 == 0) ? 32'd0 : (we && D_A2 == a3) ? wd : model_rf[D_A2];
      check("m_we", {31'd0, W_WE}, {31'd0, we});
      check("m_a3", {27'd0, W_A3}, {27'd0, a3});
      check("m_wd", W_WD, wd);
      check("m_rd1", D_RD1, r1);
      check("m_rd2", D_RD2, r2);
      if (!reset) for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
      else if (we) model_rf[a3] = wd;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_w(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] dm, input logic bj, input logic [31:0] mdu);
    W_Instr = ins; W_PC = pc; W_ALUAns = alu; W_DMRD = dm; W_b_jump = bj; W_MDUAns = mdu;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [5:0]  ops [0:20];
    logic [5:0]  fns [0:21];
    logic [4:0]  rts [0:3];
    ops = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0a, 6'h0b,
            6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2b};
    fns = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h10, 6'h11, 6'h12,
            6'h13, 6'h18, 6'h1a, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    rts = '{5'b10000, 5'b10001, 5'b00000, 5'b00001};
    ins = $urandom;
    if ($urandom_range(0, 15) == 0) return ins;
    if ($urandom_range(0, 31) == 0) return 32'd0;
    ins[31:26] = ops[$urandom_range(0, 20)];
    if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 21)];
    if (ins[31:26] == 6'h01) ins[20:16] = rts[$urandom_range(0, 3)];
    return ins;
  endfunction

  initial begin
    logic [31:0] ins;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    reset = 1'b0; D_A1 = 5'd0; D_A2 = 5'd0;
    set_w(32'h3405_1234, 32'h3000, 32'h1234, 32'h0, 1'b0, 32'h0);  // ori $5,$0,0x1234
    cyc();
    chk_en = 1'b1;
    // Reset held: ori must not write, every address reads 0.
    for (int i = 0; i < 32; i++) begin
      D_A1 = 5'(i); D_A2 = 5'(31 - i);
      @(negedge clk);
      check("rst_rd1", D_RD1, 32'd0);
      check("rst_rd2", D_RD2, 32'd0);
      check("rst_we", {31'd0, W_WE}, 32'd0);
      cyc();
    end
    reset = 1'b1; D_A1 = 5'd5; D_A2 = 5'd5;
    @(negedge clk);
    check("ori_byp1", D_RD1, 32'h1234);
    check("ori_byp2", D_RD2, 32'h1234);
    check("ori_a3", {27'd0, W_A3}, 32'd5);
    cyc();
    set_w(32'h0, 32'h3004, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    check("ori_arr", D_RD1, 32'h1234);
    check("bubble_we", {31'd0, W_WE}, 32'd0);
    cyc();
    set_w(32'h0C00_0C00, 32'h3000, 32'h0, 32'h0, 1'b0, 32'h0);  // jal
    @(negedge clk);
    check("jal_a3", {27'd0, W_A3}, 32'd31);
    check("jal_wd", W_WD, 32'h3008);
    cyc();
    set_w(32'h0411_0004, 32'h3010, 32'h0, 32'h0, 1'b0, 32'h0);  // bgezal, not taken
    D_A1 = 5'd31;
    @(negedge clk);
    check("bgezal_nt_we", {31'd0, W_WE}, 32'd0);
    check("bgezal_nt_wd", W_WD, 32'd0);
    check("jal_arr", D_RD1, 32'h3008);
    cyc();
    W_b_jump = 1'b1;
    cyc();
    set_w(32'h8C00_0000, 32'h3014, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0);  // lw $0
    @(negedge clk);
    check("bgezal_t_arr", D_RD1, 32'h3018);
    D_A1 = 5'd0;
    #1;
    check("lw0_rd1", D_RD1, 32'd0);
    check("lw0_a3", {27'd0, W_A3}, 32'd0);
    check("lw0_we", {31'd0, W_WE}, 32'd0);
    cyc();
    set_w(32'h0000_4012, 32'h3018, 32'h0, 32'h0, 1'b0, 32'hFFFF_0000);  // mflo $8
    cyc();
    set_w(32'hAC08_0000, 32'h301C, 32'h8, 32'h0, 1'b0, 32'h0);  // sw
    D_A1 = 5'd8;
    @(negedge clk);
    check("sw_we", {31'd0, W_WE}, 32'd0);
    check("mflo_arr", D_RD1, 32'hFFFF_0000);
    cyc();
    set_w(32'h03E0_4809, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'h0);  // jalr $9, wraps
    D_A1 = 5'd9;
    @(negedge clk);
    check("jalr_wrap", W_WD, 32'h0000_0004);
    check("jalr_byp", D_RD1, 32'h0000_0004);
    cyc();
    // Randomized phase, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      ins = rand_instr();
      set_w(ins, $urandom, $urandom, $urandom, 1'($urandom), $urandom);
      reset = ($urandom_range(0, 63) != 0);
      case ($urandom_range(0, 3))
        0: begin D_A1 = ins[20:16]; D_A2 = ins[15:11]; end
        1: begin D_A1 = ins[15:11]; D_A2 = ins[15:11]; end
        2: begin D_A1 = 5'd31; D_A2 = 5'($urandom); end
        default: begin D_A1 = 5'($urandom); D_A2 = 5'($urandom); end
      endcase
      cyc();
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/w_stage_grf.md
Name: w_stage_grf

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs, W_* side.
- Decodes W_Instr to pick the destination register and the writeback data source, then writes the 32x32 general register file.
- Provides the two decode-stage read ports with internal write-through bypass.
- Exports the W-stage destination and data for the hazard/forwarding unit.

Parameters:
- LINK_OFFSET, 8: value added to W_PC for link writes (jal/jalr/bgezal/bltzal).
- ZERO_REG, 0: hardwired-zero register index. Writes to it are dropped; reads of it return 0.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low (reset==0 clears on posedge clk).
- W_PC  in  32  PC of the instruction in W.
- W_Instr  in  32  instruction word in W. 0 is a bubble.
- W_ALUAns  in  32  ALU result.
- W_DMRD  in  32  data-memory read data, already byte/half extended.
- W_b_jump  in  1  branch-condition result, used by conditional-link branches.
- W_MDUAns  in  32  HI/LO value for mfhi/mflo.
- D_A1  in  5  read address, port 1.
- D_A2  in  5  read address, port 2.
- D_RD1  out  32  read data, port 1.
- D_RD2  out  32  read data, port 2.
- W_A3  out  5  effective destination. 0 when no write.
- W_WD  out  32  writeback data. 0 when W_A3==0.
- W_WE  out  1  register-file write strobe this cycle.

Behaviour:
- Destination and source decode (combinational):
  - R-type arithmetic, logic and shift (opcode 0; addu, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav) -> rd <= W_ALUAns.
  - mfhi/mflo -> rd <= W_MDUAns.
  - jalr -> rd <= W_PC+LINK_OFFSET.
  - ori, andi, xori, addiu, lui, slti, sltiu -> rt <= W_ALUAns.
  - lw, lh, lhu, lb, lbu -> rt <= W_DMRD.
  - jal -> $31 <= W_PC+LINK_OFFSET.
  - REGIMM bgezal (rt=10001) and bltzal (rt=10000) -> $31 <= W_PC+LINK_OFFSET, only when W_b_jump=1. Otherwise no write.
  - All other opcodes (stores, branches, j, jr, mult/div, mthi/mtlo, unknown) -> W_A3=0.
- Write enable:
  - W_WE = reset & (W_A3 != ZERO_REG).
  - W_A3 and W_WD are forced to 0 whenever W_WE=0, so the forwarding unit never matches.
- Write:
  - On posedge clk with W_WE=1, reg[W_A3] <= W_WD.
  - One-cycle write latency into the array.
- Reads are combinational.
  - D_RDx = 0 if D_Ax==0.
  - Else W_WD if W_WE && D_Ax==W_A3 (same-cycle bypass).
  - Else reg[D_Ax].
- Reset:
  - When reset==0 at posedge clk, all 32 entries are cleared to 0 and no write occurs.
  - While reset is low, W_WE=0, so bypass is inactive and D_RDx show the array contents.
  - Reset mid-stream discards the W instruction.
- Boundaries:
  - Bubble (Instr 0 = sll $0,$0,0) -> no write.
  - Write to $0 is dropped and not forwarded.
  - D_A1==D_A2==W_A3 -> both ports bypass.
  - Link adder wraps modulo 2^32.
  - Entry 0 is never written and always reads 0.

Optional Feature:
- Macro: GRF_TRACE_EN.
- Defined: on each posedge with W_WE=1 and reset=1, the block prints "@%h: $%d <= %h" with W_PC, W_A3, W_WD, in write order, for the judger comparison flow.
- Undefined: no display code is compiled and behaviour is otherwise identical.

Decomposition:
- Shared def package holds:
  - opcode constants (OP_RTYPE, OP_REGIMM, OP_JAL, OP_LW...);
  - funct constants (FN_ADDU, FN_JALR, FN_MFHI...);
  - REGIMM rt codes (RT_BGEZAL, RT_BLTZAL);
  - source-select encoding (WD_ALU, WD_DM, WD_PC8, WD_MDU);
  - REG_RA = 31.
- One sub-module, w_dest_decode, is natural: pure combinational W_Instr/W_b_jump -> {A3, WD source select}.
- The GRF array, bypass and trace logic stay in w_stage_grf.

Test Plan:
- Reset low one cycle, then read all 32 addresses -> all 0. W_WE stays 0 during reset even with Instr=ori $5,$0,0x1234.
- W_Instr=ori $5,$0,0x1234, W_ALUAns=0x1234, D_A1=5 in the same cycle -> D_RD1=0x1234 via bypass. Next cycle, Instr=0 -> D_RD1=0x1234 from the array.
- W_Instr=jal, W_PC=0x3000 -> W_A3=31, W_WD=0x3008, reg[31]=0x3008.
- bgezal with W_b_jump=0 -> W_WE=0, reg[31] unchanged. Same with W_b_jump=1, W_PC=0x3010 -> reg[31]=0x3018.
- lw $0 with W_DMRD=0xDEADBEEF -> W_WE=0, W_A3=0, D_RD1(A1=0)=0.
- mflo $8 with W_MDUAns=0xFFFF0000, and sw in the next cycle -> reg[8]=0xFFFF0000 and the sw cycle has W_WE=0. With GRF_TRACE_EN, exactly one line "@...: $ 8 <= ffff0000".
